// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Job sequencer for a weight-stationary dim_p x dim_p systolic
//            array. One job per start handshake, run as four phases:
//            weight load, skewed activation streaming, result drain, done.
// Ports    : clk_i          - clock
//            reset_i        - asynchronous active-high reset
//            start_i/len_i  - job request and activation-vector count
//            ready_o        - idle, able to accept a job
//            busy_o         - job in progress
//            weight_load_o  - weight load enable
//            weight_row_o   - row of the weight being loaded
//            act_valid_o    - per-row activation valid (skewed)
//            stream_t_o     - stream cycle counter (row r index = t - r)
//            drain_o        - result drain / capture enable
//            done_o         - single-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int dim_p       = 4,
    parameter int len_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [len_width_p-1:0]   len_i,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     weight_load_o,
    output logic [$clog2(dim_p)-1:0] weight_row_o,
    output logic [dim_p-1:0]         act_valid_o,
    output logic [len_width_p:0]     stream_t_o,
    output logic                     drain_o,
    output logic                     done_o
);

    localparam int CW = $clog2(dim_p);
    localparam int TW = len_width_p + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [len_width_p-1:0] len_q,   len_d;
    logic [CW-1:0]          cnt_q,   cnt_d;   // shared by LOAD and DRAIN
    logic [TW-1:0]          t_q,     t_d;

    // Last stream cycle is t = len + dim_p - 2; TW bits hold it without wrap.
    logic [TW-1:0]          w_t_last;
    assign w_t_last = {1'b0, len_q} + TW'(dim_p - 2);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    cnt_d   = '0;
                    t_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == CW'(dim_p - 1)) begin
                    cnt_d   = '0;
                    // An empty job has nothing to stream or drain.
                    state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STREAM: begin
                if (t_q == w_t_last) begin
                    t_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(dim_p - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign ready_o       = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign weight_load_o = (state_q == ST_LOAD);
    assign weight_row_o  = (state_q == ST_LOAD)   ? cnt_q : '0;
    assign stream_t_o    = (state_q == ST_STREAM) ? t_q   : '0;
    assign drain_o       = (state_q == ST_DRAIN);
    assign done_o        = (state_q == ST_DONE);

    // Row r is valid for t in [r, r + len). One extra bit of width keeps
    // r + len from wrapping at the maximum job length.
    logic [TW:0] w_t_ext;
    assign w_t_ext = {1'b0, t_q};

    for (genvar r = 0; r < dim_p; r++) begin : g_row
        logic [TW:0] w_end;
        assign w_end = (TW + 1)'(r) + {2'b00, len_q};
        if (r == 0) begin : g_first
            assign act_valid_o[r] = (state_q == ST_STREAM) && (w_t_ext < w_end);
        end else begin : g_rest
            assign act_valid_o[r] = (state_q == ST_STREAM) &&
                                    (w_t_ext >= (TW + 1)'(r)) &&
                                    (w_t_ext < w_end);
        end
    end

endmodule
`default_nettype wire
